unary_binary_matmul: RTL and testbench

UNARY_BINARY_MATMUL -- requirements
Module: unary_binary_matmul

---
 rtl/unary_binary_matmul.sv | 147 ++++++++++++++
 tb/tb_unary_binary_matmul.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/unary_binary_matmul.sv
// Unary x binary matrix multiplier: A is consumed as time-coded unary
// pulses per column slot, B rows are added into per-row accumulators.
module unary_binary_matmul #(
  parameter int BIT_WIDTH  = 3,
  parameter int A_ROW      = 2,
  parameter int A_COL      = 2,
  parameter int B_COL      = 2,
  parameter int EARLY_TERM = 0,
  localparam int ACC_W     = 2 * BIT_WIDTH + A_COL
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  logic [A_ROW-1:0][A_COL-1:0][BIT_WIDTH-1:0] A,
  input  logic [A_COL-1:0][B_COL-1:0][BIT_WIDTH-1:0] B,
  output logic out_valid,
  input  logic out_ready,
  output logic [A_ROW-1:0][B_COL-1:0][ACC_W-1:0] C,
  output logic busy
);

  localparam int KW = (A_COL > 1) ? $clog2(A_COL) : 1;
  localparam logic [BIT_WIDTH-1:0] S = '1;
  localparam logic [KW-1:0] K_LAST = KW'(A_COL - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef logic [A_ROW-1:0][A_COL-1:0][BIT_WIDTH-1:0] amat_t;
  typedef logic [A_COL-1:0][B_COL-1:0][BIT_WIDTH-1:0] bmat_t;
  typedef logic [A_ROW-1:0][B_COL-1:0][ACC_W-1:0] cmat_t;
  typedef logic [A_ROW-1:0][BIT_WIDTH-1:0] cnt_t;

  state_t state_q, state_d;
  amat_t a_q, a_d;
  bmat_t b_q, b_d;
  cmat_t acc_q, acc_d;
  cmat_t c_q, c_d;
  cnt_t cnt_q, cnt_d;
  logic [KW-1:0] k_q, k_d;
  logic [BIT_WIDTH-1:0] t_q, t_d;

  logic [BIT_WIDTH-1:0] slot_len;
  logic slot_end;
  logic [KW-1:0] k_nx;

  // Data-dependent slots stretch to the largest unary code in column k.
  always_comb begin
    slot_len = S;
    if (EARLY_TERM != 0) begin
      slot_len = BIT_WIDTH'(1);
      for (int i = 0; i < A_ROW; i++) begin
        if (a_q[i][k_q] > slot_len) slot_len = a_q[i][k_q];
      end
    end
  end

  assign slot_end = (t_q == slot_len - BIT_WIDTH'(1));
  assign k_nx = (k_q == K_LAST) ? k_q : k_q + KW'(1);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    t_d     = t_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = A;
          b_d   = B;
          acc_d = '0;
          k_d   = '0;
          t_d   = '0;
          for (int i = 0; i < A_ROW; i++) begin
            cnt_d[i] = A[i][0];
          end
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < A_ROW; i++) begin
          if (cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - BIT_WIDTH'(1);
            for (int j = 0; j < B_COL; j++) begin
              acc_d[i][j] = acc_q[i][j]
                          + ACC_W'(b_q[k_q][j]);
            end
          end
        end
        if (slot_end) begin
          t_d = '0;
          if (k_q == K_LAST) begin
            c_d     = acc_d;
            state_d = DONE;
          end else begin
            k_d = k_nx;
            for (int i = 0; i < A_ROW; i++) begin
              cnt_d[i] = a_q[i][k_nx];
            end
          end
        end else begin
          t_d = t_q + BIT_WIDTH'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      t_q     <= t_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign C         = c_q;

endmodule

// File: tb/tb_unary_binary_matmul.sv
// Scoreboard bench: fixed-slot and early-terminating instances run
// side by side on the same operands.
module tb_unary_binary_matmul;

  typedef logic [1:0][1:0][2:0] amat_t;
  typedef logic [1:0][1:0][7:0] cmat_t;

  typedef struct {
    cmat_t c;
    int    lat;
    int    acc;
  } item_t;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic out_ready;
  amat_t A_s, B_s;

  logic ir0, ir1, ov0, ov1, bz0, bz1;
  cmat_t C0, C1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  item_t q0[$];
  item_t q1[$];
  logic p0 = 1'b0;
  logic p1 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  unary_binary_matmul #(
    .BIT_WIDTH(3), .A_ROW(2), .A_COL(2), .B_COL(2), .EARLY_TERM(0)
  ) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir0),
    .A(A_s), .B(B_s), .out_valid(ov0), .out_ready(out_ready),
    .C(C0), .busy(bz0)
  );

  unary_binary_matmul #(
    .BIT_WIDTH(3), .A_ROW(2), .A_COL(2), .B_COL(2), .EARLY_TERM(1)
  ) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1),
    .A(A_s), .B(B_s), .out_valid(ov1), .out_ready(out_ready),
    .C(C1), .busy(bz1)
  );

  function automatic amat_t m3(int x00, int x01, int x10, int x11);
    amat_t m;
    m[0][0] = 3'(x00);
    m[0][1] = 3'(x01);
    m[1][0] = 3'(x10);
    m[1][1] = 3'(x11);
    return m;
  endfunction

  function automatic cmat_t m8(int x00, int x01, int x10, int x11);
    cmat_t m;
    m[0][0] = 8'(x00);
    m[0][1] = 8'(x01);
    m[1][0] = 8'(x10);
    m[1][1] = 8'(x11);
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic score(input int d, input item_t it, input cmat_t cv);
    checks++;
    if (cv !== it.c) begin
      errors++;
      $display("FAIL C dut%0d: got %h expected %h", d, cv, it.c);
    end
    checks++;
    if (cyc - it.acc != it.lat) begin
      errors++;
      $display("FAIL latency dut%0d: got %0d expected %0d",
               d, cyc - it.acc, it.lat);
    end
  endtask

  task automatic unexpected(input int d);
    checks++;
    errors++;
    $display("FAIL spurious out_valid dut%0d: got 1 expected 0", d);
  endtask

  // Monitor: every rising out_valid consumes one scoreboard entry.
  always @(negedge clk) begin
    if (reset) begin
      p0 = 1'b0;
      p1 = 1'b0;
    end else begin
      if (ov0 && !p0) begin
        if (q0.size() == 0) unexpected(0);
        else score(0, q0.pop_front(), C0);
      end
      if (ov1 && !p1) begin
        if (q1.size() == 0) unexpected(1);
        else score(1, q1.pop_front(), C1);
      end
      p0 = ov0;
      p1 = ov1;
    end
  end

  task automatic push(input cmat_t c, input int l0, input int l1);
    item_t it;
    it.c   = c;
    it.acc = cyc;
    it.lat = l0;
    q0.push_back(it);
    it.lat = l1;
    q1.push_back(it);
  endtask

  task automatic issue(input amat_t a, input amat_t b, input cmat_t c,
                       input int l0, input int l1);
    int n;
    n = 0;
    while (!(ir0 && ir1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL in_ready timeout: got 0 expected 1");
    end
    A_s = a;
    B_s = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    push(c, l0, l1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain timeout: got %0d/%0d pending expected 0",
               q0.size(), q1.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset();
    chk("rst busy0", 32'(bz0), 0);
    chk("rst busy1", 32'(bz1), 0);
    chk("rst ready0", 32'(ir0), 1);
    chk("rst ready1", 32'(ir1), 1);
    chk("rst valid0", 32'(ov0), 0);
    chk("rst valid1", 32'(ov1), 0);
    chk("rst C0", C0, 0);
    chk("rst C1", C1, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    A_s = '0;
    B_s = '0;
    #1;
    chk_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    issue(m3(6, 7, 5, 0), m3(1, 7, 2, 3), m8(20, 63, 5, 35), 14, 13);
    drain();
    issue(m3(7, 7, 7, 7), m3(7, 7, 7, 7), m8(98, 98, 98, 98), 14, 14);
    drain();
    issue(m3(0, 0, 0, 0), m3(7, 7, 7, 7), m8(0, 0, 0, 0), 14, 2);
    drain();
    issue(m3(1, 2, 3, 4), m3(5, 6, 7, 0), m8(19, 6, 43, 18), 14, 7);
    drain();

    // Consumer stall in DONE, then immediate re-accept.
    issue(m3(2, 0, 0, 3), m3(3, 1, 4, 5), m8(6, 2, 12, 15), 14, 5);
    out_ready = 1'b0;
    n = 0;
    while (!ov0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall reach DONE", 32'(ov0), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall valid0", 32'(ov0), 1);
      chk("stall valid1", 32'(ov1), 1);
      chk("stall ready0", 32'(ir0), 0);
      chk("stall ready1", 32'(ir1), 0);
      chk("stall C0", C0, m8(6, 2, 12, 15));
      chk("stall C1", C1, m8(6, 2, 12, 15));
    end
    out_ready = 1'b1;
    A_s = m3(7, 1, 0, 0);
    B_s = m3(1, 1, 1, 2);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("idle ready0", 32'(ir0), 1);
    chk("idle ready1", 32'(ir1), 1);
    chk("idle busy0", 32'(bz0), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    push(m8(8, 9, 0, 0), 14, 8);
    chk("reaccept busy0", 32'(bz0), 1);
    chk("reaccept busy1", 32'(bz1), 1);
    drain();

    // Operand noise while busy must not leak into the result.
    issue(m3(3, 5, 4, 1), m3(2, 1, 0, 6), m8(6, 33, 8, 10), 14, 9);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      A_s = 12'($urandom);
      B_s = 12'($urandom);
      in_valid = (i < 6) ? 1'($urandom) : 1'b0;
    end
    in_valid = 1'b0;
    drain();

    // Reset in the fourth RUN cycle abandons the operation.
    issue(m3(6, 7, 5, 0), m3(1, 7, 2, 3), m8(20, 63, 5, 35), 14, 13);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_reset();
    q0.delete();
    q1.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("post-rst valid0", 32'(ov0), 0);
    chk("post-rst C0", C0, 0);
    issue(m3(6, 7, 5, 0), m3(1, 7, 2, 3), m8(20, 63, 5, 35), 14, 13);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
